seq_div_restoring: RTL and testbench
====================================

Name: seq_div_restoring

Overview:
- Sequential restoring divider: the inverse of the 4x4 shift-add multiplier in the ISCAS-style datapath benchmarks.
- Accepts a 2N-bit dividend (a product P) and an N-bit divisor on a START pulse.
- Produces an N-bit quotient and N-bit remainder after N shift-subtract cycles, then asserts READY.
- Used as a multiply/divide round-trip app for FPGA mapping and equivalence tests.

Parameters:
- WIDTH, 4, operand width N; dividend is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- START  input  1  request; sampled only when READY=1
- P  input  2*WIDTH  dividend
- B  input  WIDTH  divisor
- Q  output  WIDTH  quotient; held until the next accepted START
- R  output  WIDTH  remainder; held until the next accepted START
- READY  output  1  high when idle or done; low while computing
- DONE  output  1  one-cycle pulse when Q/R update
- OVF  output  1  overflow/divide-by-zero flag; constant 0 without the macro

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low, applied on rst_n.
- Reset values:
  - State IDLE.
  - Q=0, R=0, READY=1, DONE=0, OVF=0, counter=0.
  - Working registers cleared.
- States: IDLE, RUN, DONE_S.
- IDLE or DONE_S with START=1:
  - Latch working remainder W (WIDTH+1 bits) = {0, P[2W-1:W]}.
  - Latch shift register S = P[W-1:0] and divisor D = B.
  - Set cnt=0; go to RUN; READY drops the next cycle.
- IDLE or DONE_S with START=0: hold. DONE_S returns to IDLE after one cycle.
- RUN, one step per cycle:
  - {W,S} <<= 1, with W taking S's MSB.
  - T = W - {0,D}, computed in WIDTH+1 bits.
  - If T is non-negative: W=T and S[0]=1; else S[0]=0.
  - cnt++.
- RUN, step with cnt=WIDTH-1:
  - Registered this edge: Q=S, R=W[WIDTH-1:0], DONE=1, READY=1.
  - Next state DONE_S.
- Latency:
  - START accepted at edge k; READY=0 from k+1.
  - Results, DONE and READY=1 appear at edge k+WIDTH.
  - A back-to-back START is accepted on the same edge READY is seen high.
- START while READY=0 (RUN): ignored; no queueing.
- Q/R change only on a completing step. They are stable through IDLE and during the next RUN until it completes.
- Divisor 0, or P high half >= B, without the macro:
  - Runs the full WIDTH steps.
  - Q/R are exactly the algorithm's register contents, bit-accurate to the model above.
  - DIVISOR 0 gives Q = all ones.
- Reset mid-RUN: immediate return to reset values; the in-flight operation is discarded.
- No arithmetic wraps in W: WIDTH+1 bits are sufficient by construction.

Optional Feature:
- Macro: SEQ_DIV_OVF_DETECT_EN.
- With the macro:
  - At START acceptance, if B==0 or P[2W-1:W] >= B: skip RUN.
  - At the next edge: OVF=1, Q=all ones, R=all ones, DONE=1, READY stays 1, go to DONE_S.
  - OVF clears on the next accepted START or on reset.
- Without the macro: OVF tied 0; overflow cases run the normal WIDTH cycles.

Decomposition:
- Package seq_div_pkg:
  - State enum (IDLE, RUN, DONE_S).
  - Function clog2 for the counter width.
  - Localparam default width 4.
- One sub-module, seq_div_step: combinational single restoring step, WIDTH parameter.
  - Inputs: W, S, D. Outputs: next W, next S.
  - Instantiated once in the top-level block.

Test Plan:
- Divide with remainder: P=0x64 (100), B=7, START one cycle -> READY low 4 cycles, then Q=14, R=2, DONE pulse 1 cycle, OVF=0.
- Exact division and max: P=0x2D, B=9 -> Q=5, R=0. Then back-to-back START with P=0x7F, B=8 -> Q=15, R=7.
- Zero dividend: P=0x00, B=5 -> Q=0, R=0. START pulses during RUN with other operands -> ignored; result unchanged.
- Reset mid-op: assert rst_n=0 at the 2nd RUN cycle -> Q=0, R=0, READY=1, DONE=0 asynchronously. Next operation P=0x64, B=7 is correct.
- Overflow: P=0x90, B=5.
  - With macro: OVF=1, Q=0xF, R=0xF, DONE one edge after START.
  - Without macro: 4-cycle run, OVF=0, Q/R match the bit-accurate model.
- Divide by zero: P=0x12, B=0.
  - With macro: OVF=1.
  - Without macro: Q=0xF after 4 cycles, R per model.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/seq_div_restoring_if.sv
// Request/result bundle of the divider, plus the FSM state for observation.
interface seq_div_restoring_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    // START is a request sampled only while READY=1; there is no backpressure
    // beyond READY, and a START seen while READY=0 is dropped, never queued.
    logic                 START;
    logic [2*WIDTH-1:0]   P;
    logic [WIDTH-1:0]     B;
    logic [WIDTH-1:0]     Q;
    logic [WIDTH-1:0]     R;
    logic                 READY;
    logic                 DONE;
    logic                 OVF;
    state_t               dbg_state;

    modport master (
        output START, P, B,
        input  Q, R, READY, DONE, OVF, dbg_state
    );

    modport slave (
        input  START, P, B,
        output Q, R, READY, DONE, OVF, dbg_state
    );

endinterface

// File: rtl/seq_div_step.sv
// One restoring shift-subtract step on the working remainder and quotient shift register.
module seq_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   w,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   w_next,
    output logic [WIDTH-1:0] s_next
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] diff;

    // The extra top bit of diff is the borrow, so "non-negative" is an
    // unsigned compare even when the shifted remainder uses its top bit.
    always_comb begin
        w_shift = {w[WIDTH-1:0], s[WIDTH-1]};
        diff    = {1'b0, w_shift} - {2'b00, d};
        if (!diff[WIDTH+1]) begin
            w_next = diff[WIDTH:0];
            s_next = {s[WIDTH-2:0], 1'b1};
        end else begin
            w_next = w_shift;
            s_next = {s[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_div_restoring.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor in N steps.
// Optional overflow/divide-by-zero short cut enabled by SEQ_DIV_OVF_DETECT_EN.
module seq_div_restoring
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_div_restoring_if.slave  bus
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH:0]   w, w_next;
    logic [WIDTH-1:0] s, s_next, d, q, r;
    logic [CW-1:0]    cnt;
    logic             ready, done;
    logic             load, step_en, finish, ovf_hit;
    logic [WIDTH-1:0] p_hi, p_lo;

    assign p_hi = bus.P[2*WIDTH-1:WIDTH];
    assign p_lo = bus.P[WIDTH-1:0];

`ifdef SEQ_DIV_OVF_DETECT_EN
    logic ovf;
    assign ovf_hit = (bus.B == '0) || (p_hi >= bus.B);
`else
    assign ovf_hit = 1'b0;
`endif

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .w      (w),
        .s      (s),
        .d      (d),
        .w_next (w_next),
        .s_next (s_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE_S: begin
                if (bus.START) begin
                    load       = 1'b1;
                    state_next = ovf_hit ? DONE_S : RUN;
                end else if (state == DONE_S) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE_S;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Q/R only move on the completing step (or an overflow short cut).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w     <= '0;
            s     <= '0;
            d     <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
`ifdef SEQ_DIV_OVF_DETECT_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                w   <= {1'b0, p_hi};
                s   <= p_lo;
                d   <= bus.B;
                cnt <= '0;
                if (ovf_hit) begin
                    q    <= '1;
                    r    <= '1;
                    done <= 1'b1;
                end else begin
                    ready <= 1'b0;
                end
`ifdef SEQ_DIV_OVF_DETECT_EN
                ovf <= ovf_hit;
`endif
            end else if (step_en) begin
                w   <= w_next;
                s   <= s_next;
                cnt <= cnt + 1'b1;
                if (finish) begin
                    q     <= s_next;
                    r     <= w_next[WIDTH-1:0];
                    done  <= 1'b1;
                    ready <= 1'b1;
                end
            end
        end
    end

    assign bus.Q         = q;
    assign bus.R         = r;
    assign bus.READY     = ready;
    assign bus.DONE      = done;
    assign bus.dbg_state = state;
`ifdef SEQ_DIV_OVF_DETECT_EN
    assign bus.OVF       = ovf;
`else
    assign bus.OVF       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_restoring.sv
// Bench for seq_div_restoring: transaction-level model with a result queue, per-cycle compare,
// directed literal cases and random traffic. Follows SEQ_DIV_OVF_DETECT_EN when defined.
module tb_seq_div_restoring;
    import seq_div_pkg::*;

    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run_cmp = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_div_restoring_if #(.WIDTH(WIDTH)) bus ();

    seq_div_restoring #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Long division of the dividend one bit at a time; the remainder lives in
    // WIDTH+1 bits, so anything shifted past that is lost.
    function automatic logic [2*WIDTH-1:0] div_model(input logic [2*WIDTH-1:0] p,
                                                     input logic [WIDTH-1:0] b);
        int unsigned w, low, q, bitv;
        w   = int'(p) >> WIDTH;
        low = int'(p) & ((1 << WIDTH) - 1);
        q   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            bitv = (low >> (WIDTH - 1 - i)) & 1;
            w    = ((w << 1) | bitv) % (1 << (WIDTH + 1));
            if (w >= int'(b)) begin
                w = w - int'(b);
                q = (q << 1) | 1;
            end else begin
                q = q << 1;
            end
        end
        return {WIDTH'(q), WIDTH'(w)};
    endfunction

    function automatic logic ovf_case(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] b);
`ifdef SEQ_DIV_OVF_DETECT_EN
        return (b == 0) || ((int'(p) >> WIDTH) >= int'(b));
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: accepted requests queue their answer, which appears WIDTH edges later.
    logic [2*WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0]   m_q, m_r;
    logic               m_ready, m_done, m_ovf;
    int                 m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            m_r     <= '0;
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_ovf   <= 1'b0;
            m_left  <= 0;
            exp_q.delete();
        end else begin
            m_done <= 1'b0;
            if (m_ready && bus.START) begin
                if (ovf_case(bus.P, bus.B)) begin
                    m_q    <= '1;
                    m_r    <= '1;
                    m_ovf  <= 1'b1;
                    m_done <= 1'b1;
                end else begin
                    exp_q.push_back(div_model(bus.P, bus.B));
                    m_ovf   <= 1'b0;
                    m_ready <= 1'b0;
                    m_left  <= WIDTH - 1;
                end
            end else if (!m_ready) begin
                if (m_left == 0) begin
                    m_q     <= exp_q[0][2*WIDTH-1:WIDTH];
                    m_r     <= exp_q[0][WIDTH-1:0];
                    void'(exp_q.pop_front());
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("cyc_Q",     32'(bus.Q),     32'(m_q));
            chk("cyc_R",     32'(bus.R),     32'(m_r));
            chk("cyc_READY", 32'(bus.READY), 32'(m_ready));
            chk("cyc_DONE",  32'(bus.DONE),  32'(m_done));
            chk("cyc_OVF",   32'(bus.OVF),   32'(m_ovf));
        end
    end

    // Drives a one-cycle START; returns just after the accepting edge.
    task automatic start_op(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] b);
        bus.P     = p;
        bus.B     = b;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic finish_check(input int n, input int eq, input int er, input string name);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (i < n) chk({name, "_busy"}, 32'(bus.READY), 0);
        end
        chk({name, "_Q"},     32'(bus.Q), eq);
        chk({name, "_R"},     32'(bus.R), er);
        chk({name, "_DONE"},  32'(bus.DONE), 1);
        chk({name, "_READY"}, 32'(bus.READY), 1);
        chk({name, "_OVF"},   32'(bus.OVF), 0);
    endtask

    task automatic ovf_or_run(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] b,
                              input int eq, input int er, input string name);
        start_op(p, b);
`ifdef SEQ_DIV_OVF_DETECT_EN
        chk({name, "_OVF"},   32'(bus.OVF), 1);
        chk({name, "_Q"},     32'(bus.Q), 32'hF);
        chk({name, "_R"},     32'(bus.R), 32'hF);
        chk({name, "_DONE"},  32'(bus.DONE), 1);
        chk({name, "_READY"}, 32'(bus.READY), 1);
`else
        finish_check(WIDTH, eq, er, name);
`endif
    endtask

    initial begin
        bus.START = 1'b0;
        bus.P     = '0;
        bus.B     = '0;

        chk("model_100_7",  32'(div_model(8'h64, 4'd7)), 32'hE2);
        chk("model_127_8",  32'(div_model(8'h7F, 4'd8)), 32'hF7);
        chk("model_90_5",   32'(div_model(8'h90, 4'd5)), 32'hF5);
        chk("model_12_0",   32'(div_model(8'h12, 4'd0)), 32'hF2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_Q",     32'(bus.Q), 0);
        chk("rst_R",     32'(bus.R), 0);
        chk("rst_READY", 32'(bus.READY), 1);
        chk("rst_DONE",  32'(bus.DONE), 0);
        chk("rst_OVF",   32'(bus.OVF), 0);
        rst_n   = 1'b1;
        run_cmp = 1'b1;
        @(posedge clk);
        #1;

        start_op(8'h64, 4'd7);
        finish_check(WIDTH, 14, 2, "div100_7");
        @(posedge clk);
        #1;
        chk("div100_7_pulse", 32'(bus.DONE), 0);
        chk("div100_7_hold",  32'(bus.Q), 14);

        start_op(8'h2D, 4'd9);
        finish_check(WIDTH, 5, 0, "div45_9");
        start_op(8'h7F, 4'd8);
        finish_check(WIDTH, 15, 7, "b2b127_8");

        start_op(8'h64, 4'd7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_Q",     32'(bus.Q), 0);
        chk("midrst_R",     32'(bus.R), 0);
        chk("midrst_READY", 32'(bus.READY), 1);
        chk("midrst_DONE",  32'(bus.DONE), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        start_op(8'h64, 4'd7);
        finish_check(WIDTH, 14, 2, "post_rst");

        start_op(8'h00, 4'd5);
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        bus.P     = 8'hFF;
        bus.B     = 4'd3;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        finish_check(WIDTH - 2, 0, 0, "zero_ign");

        ovf_or_run(8'h90, 4'd5, 15, 5, "ovf90_5");
        @(posedge clk);
        #1;
        ovf_or_run(8'h12, 4'd0, 15, 2, "divz12");
        @(posedge clk);
        #1;

        for (int c = 0; c < 2000; c++) begin
            bus.START = ($urandom_range(0, 2) == 0);
            bus.P     = 8'($urandom);
            bus.B     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            @(posedge clk);
            #1;
        end
        bus.START = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
